rrd_issue_arbiter: RTL and testbench
====================================

Name: rrd_issue_arbiter

Overview:
- Shares one register-read decode slot between two issue requesters: the memory issue slot (req0) and the FP-store issue slot (req1).
- Round-robin arbitration feeds a single-entry pipeline register with a valid/ready output toward the register-read stage.
- Applies branch-resolution mask clearing, mispredict kill and pipeline flush to both the incoming and the held uop.
- Keeps a saturating conflict counter for performance tuning.

Parameters:
- BR_W, 20, branch-mask width.
- IMM_W, 20, packed-immediate width.
- IDX_W, 7, rob_idx and pdst width.
- CNT_W, 16, conflict-counter width.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  pipeline flush; drops the held uop and blocks acceptance this cycle.
- brupdate_resolve_mask  in  BR_W  branches resolved this cycle.
- brupdate_mispredict_mask  in  BR_W  branches mispredicted this cycle.
- reqN_valid  in  1  (N=0,1) requester N presents a uop.
- reqN_ready  out  1  uop accepted on this edge when reqN_valid is also high.
- reqN_uopc  in  7  micro-op code.
- reqN_br_mask  in  BR_W  branch dependency mask.
- reqN_imm_packed  in  IMM_W  packed immediate.
- reqN_rob_idx  in  IDX_W  ROB index.
- reqN_pdst  in  IDX_W  physical destination.
- out_valid  out  1  held uop valid and not killed.
- out_ready  in  1  downstream consumes the uop on this edge.
- out_uopc, out_br_mask, out_imm_packed, out_rob_idx, out_pdst  out  same widths  held uop fields.
- out_src  out  1  requester index of the held uop.
- conflict_count  out  CNT_W  saturating count of arbitration-conflict cycles.

Behaviour:
- Reset (reset_n=0 at edge):
  - Held valid=0; all out_* fields=0; out_src=0.
  - rr pointer=0, meaning req0 has priority.
  - conflict_count=0.
- Latency is 1 cycle, request handshake to out_valid. Throughput is 1 uop/cycle.
- can_accept = !flush & (!held_valid | (out_valid & out_ready) | held_killed).
- Grant:
  - Only one reqN_valid: grant N.
  - Both valid: grant rr pointer.
  - reqN_ready = can_accept & grant==N.
  - Ready is combinational from valids. Requesters must not make valid depend on ready.
- Pointer update: after any accepted handshake from N, pointer = 1-N. Otherwise unchanged. Flush does not change the pointer.
- Load on handshake:
  - Copy fields into the held register.
  - Stored br_mask = reqN_br_mask & ~brupdate_resolve_mask.
  - out_src=N.
- Incoming kill: if (reqN_br_mask & brupdate_mispredict_mask) != 0 at handshake, the requester is still acked (ready=1), the uop is discarded, held_valid becomes 0 and the pointer still advances.
- Held uop, each cycle it stays: br_mask &= ~brupdate_resolve_mask.
- held_killed = held_valid & ((held_br_mask & brupdate_mispredict_mask) != 0).
  - out_valid = held_valid & !held_killed & !flush. Combinational gating in the kill cycle.
  - held_valid is cleared at the next edge unless a new uop loads.
- Flush has priority over everything:
  - out_valid=0 and both reqN_ready=0 in the flush cycle.
  - held_valid=0 at the next edge.
- Fields of the held uop are stable while out_valid & !out_ready, except br_mask bits being cleared by resolves.
- Consume and load in the same cycle: the new uop replaces the old one with no bubble.
- conflict_count: +1 on each cycle with req0_valid & req1_valid & can_accept. Saturates at all-ones. Only reset clears it.
- Resolve and mispredict of the same bit in one cycle: the kill wins.

Test Plan:
- Both requesters valid continuously, out_ready=1, pointer=0 after reset -> grants alternate 0,1,0,1, out_valid=1 every cycle from cycle 1, conflict_count=4 after 4 cycles.
- req0 only, out_ready=0 for 3 cycles -> one uop held; req0_ready=0 for 3 cycles; out fields constant; accepted on the cycle out_ready rises, with no bubble.
- Held uop br_mask=0x00004, resolve_mask=0x00004 -> out_br_mask=0x00000 next cycle and out_valid stays 1. A later mispredict_mask=0x00004 does not kill it.
- Held uop br_mask=0x00010, mispredict_mask=0x00010 -> out_valid=0 in the same cycle and held_valid=0 next edge. A req1 uop presented that cycle is accepted and appears next cycle.
- Incoming req1 br_mask=0x80000 with mispredict_mask=0x80000 -> req1_ready=1, out_valid=0 next cycle, pointer=0.
- flush=1 with a held uop and both reqs valid -> out_valid=0, both readies 0, empty next cycle, pointer unchanged; reset_n=0 mid-stream -> all outputs 0 and conflict_count=0.

Source files
------------

// File: rtl/rrd_issue_arbiter.sv
// Purpose: round-robin arbiter sharing one register-read decode slot between the memory and FP-store issue slots.
// Latency: 1 cycle from request handshake to out_valid; sustains 1 uop/cycle when the held entry drains.
// Backpressure: req ready only when the single held entry is empty, draining, or killed; flush blocks acceptance.
module rrd_issue_arbiter #(
    parameter int BR_W  = 20,
    parameter int IMM_W = 20,
    parameter int IDX_W = 7,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [BR_W-1:0]  brupdate_resolve_mask,
    input  logic [BR_W-1:0]  brupdate_mispredict_mask,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [6:0]       req0_uopc,
    input  logic [BR_W-1:0]  req0_br_mask,
    input  logic [IMM_W-1:0] req0_imm_packed,
    input  logic [IDX_W-1:0] req0_rob_idx,
    input  logic [IDX_W-1:0] req0_pdst,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [6:0]       req1_uopc,
    input  logic [BR_W-1:0]  req1_br_mask,
    input  logic [IMM_W-1:0] req1_imm_packed,
    input  logic [IDX_W-1:0] req1_rob_idx,
    input  logic [IDX_W-1:0] req1_pdst,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_uopc,
    output logic [BR_W-1:0]  out_br_mask,
    output logic [IMM_W-1:0] out_imm_packed,
    output logic [IDX_W-1:0] out_rob_idx,
    output logic [IDX_W-1:0] out_pdst,
    output logic             out_src,

    output logic [CNT_W-1:0] conflict_count
);

    typedef struct packed {
        logic [6:0]       uopc;
        logic [BR_W-1:0]  br_mask;
        logic [IMM_W-1:0] imm_packed;
        logic [IDX_W-1:0] rob_idx;
        logic [IDX_W-1:0] pdst;
    } uop_t;

    // Held pipeline entry and arbitration state.
    uop_t             held_q, held_d;
    logic             held_valid_q, held_valid_d;
    logic             src_q, src_d;
    logic             rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Combinational datapath signals.
    uop_t             req0_uop, req1_uop, sel_uop;
    logic             held_killed;
    logic             consume;
    logic             can_accept;
    logic             grant;
    logic             any_req;
    logic             handshake;
    logic             incoming_kill;
    logic             conflict;

    assign req0_uop = '{uopc: req0_uopc, br_mask: req0_br_mask, imm_packed: req0_imm_packed,
                        rob_idx: req0_rob_idx, pdst: req0_pdst};
    assign req1_uop = '{uopc: req1_uopc, br_mask: req1_br_mask, imm_packed: req1_imm_packed,
                        rob_idx: req1_rob_idx, pdst: req1_pdst};

    // A mispredict on any branch the held uop still depends on kills it this cycle.
    assign held_killed = held_valid_q && ((held_q.br_mask & brupdate_mispredict_mask) != '0);
    assign out_valid   = held_valid_q && !held_killed && !flush;
    assign consume     = out_valid && out_ready;
    assign can_accept  = !flush && (!held_valid_q || consume || held_killed);

    // Grant: a lone requester always wins; on a tie the rr pointer decides.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = rr_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready    = can_accept && (grant == 1'b0);
    assign req1_ready    = can_accept && (grant == 1'b1);
    assign any_req       = req0_valid || req1_valid;
    assign handshake     = can_accept && any_req;
    assign sel_uop       = grant ? req1_uop : req0_uop;
    assign incoming_kill = (sel_uop.br_mask & brupdate_mispredict_mask) != '0;
    assign conflict      = req0_valid && req1_valid && can_accept;

    // Next state of the held entry, pointer and conflict counter.
    always_comb begin
        held_d         = held_q;
        held_d.br_mask = held_q.br_mask & ~brupdate_resolve_mask;
        held_valid_d   = held_valid_q;
        src_d          = src_q;
        rr_d           = rr_q;
        cnt_d          = cnt_q;

        if (flush) begin
            held_valid_d = 1'b0;
        end else if (handshake) begin
            // A uop killed on arrival is still acked and still advances the pointer.
            held_d         = sel_uop;
            held_d.br_mask = sel_uop.br_mask & ~brupdate_resolve_mask;
            held_valid_d   = !incoming_kill;
            src_d          = grant;
            rr_d           = !grant;
        end else if (held_killed || consume) begin
            held_valid_d = 1'b0;
        end

        if (conflict && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            held_q       <= '0;
            held_valid_q <= 1'b0;
            src_q        <= 1'b0;
            rr_q         <= 1'b0;
            cnt_q        <= '0;
        end else begin
            held_q       <= held_d;
            held_valid_q <= held_valid_d;
            src_q        <= src_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_uopc       = held_q.uopc;
    assign out_br_mask    = held_q.br_mask;
    assign out_imm_packed = held_q.imm_packed;
    assign out_rob_idx    = held_q.rob_idx;
    assign out_pdst       = held_q.pdst;
    assign out_src        = src_q;
    assign conflict_count = cnt_q;

endmodule

// File: tb/tb_rrd_issue_arbiter.sv
// Purpose: directed self-checking bench for rrd_issue_arbiter.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled 1 unit later.
// Backpressure: out_ready driven explicitly per scenario.
module tb_rrd_issue_arbiter;
    localparam int BR_W  = 20;
    localparam int IMM_W = 20;
    localparam int IDX_W = 7;
    localparam int CNT_W = 16;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             flush;
    logic [BR_W-1:0]  brupdate_resolve_mask, brupdate_mispredict_mask;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [6:0]       req0_uopc, req1_uopc, out_uopc;
    logic [BR_W-1:0]  req0_br_mask, req1_br_mask, out_br_mask;
    logic [IMM_W-1:0] req0_imm_packed, req1_imm_packed, out_imm_packed;
    logic [IDX_W-1:0] req0_rob_idx, req1_rob_idx, out_rob_idx;
    logic [IDX_W-1:0] req0_pdst, req1_pdst, out_pdst;
    logic             out_valid, out_ready, out_src;
    logic [CNT_W-1:0] conflict_count;

    int checks   = 0;
    int failures = 0;

    rrd_issue_arbiter #(.BR_W(BR_W), .IMM_W(IMM_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .brupdate_resolve_mask(brupdate_resolve_mask),
        .brupdate_mispredict_mask(brupdate_mispredict_mask),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_uopc(req0_uopc),
        .req0_br_mask(req0_br_mask), .req0_imm_packed(req0_imm_packed),
        .req0_rob_idx(req0_rob_idx), .req0_pdst(req0_pdst),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_uopc(req1_uopc),
        .req1_br_mask(req1_br_mask), .req1_imm_packed(req1_imm_packed),
        .req1_rob_idx(req1_rob_idx), .req1_pdst(req1_pdst),
        .out_valid(out_valid), .out_ready(out_ready), .out_uopc(out_uopc),
        .out_br_mask(out_br_mask), .out_imm_packed(out_imm_packed),
        .out_rob_idx(out_rob_idx), .out_pdst(out_pdst), .out_src(out_src),
        .conflict_count(conflict_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [6:0] op, input logic [BR_W-1:0] br,
                            input logic [IMM_W-1:0] imm, input logic [IDX_W-1:0] rob,
                            input logic [IDX_W-1:0] pd);
        req0_valid = v; req0_uopc = op; req0_br_mask = br;
        req0_imm_packed = imm; req0_rob_idx = rob; req0_pdst = pd;
    endtask

    task automatic set_req1(input logic v, input logic [6:0] op, input logic [BR_W-1:0] br,
                            input logic [IMM_W-1:0] imm, input logic [IDX_W-1:0] rob,
                            input logic [IDX_W-1:0] pd);
        req1_valid = v; req1_uopc = op; req1_br_mask = br;
        req1_imm_packed = imm; req1_rob_idx = rob; req1_pdst = pd;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        brupdate_resolve_mask = '0; brupdate_mispredict_mask = '0;
        set_req0(1'b0, 7'h0, '0, '0, '0, '0);
        set_req1(1'b0, 7'h0, '0, '0, '0, '0);
        tick();
        tick();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_uopc", 32'(out_uopc), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_conflict", 32'(conflict_count), 32'd0);

        // Both requesters valid continuously: grants alternate 0,1,0,1.
        reset_n = 1'b1; out_ready = 1'b1;
        set_req0(1'b1, 7'h10, '0, 20'h00111, 7'd1, 7'd2);
        set_req1(1'b1, 7'h20, '0, 20'h00222, 7'd3, 7'd4);
        #1;
        chk("rr_first_r0", 32'(req0_ready), 32'd1);
        chk("rr_first_r1", 32'(req1_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("rr_out_valid", 32'(out_valid), 32'd1);
            chk("rr_out_src", 32'(out_src), 32'(i % 2));
            chk("rr_out_uopc", 32'(out_uopc), (i % 2 == 0) ? 32'h10 : 32'h20);
            chk("rr_count", 32'(conflict_count), 32'(i + 1));
        end
        chk("rr_imm", 32'(out_imm_packed), 32'h00222);
        chk("rr_pdst", 32'(out_pdst), 32'd4);
        set_req0(1'b0, 7'h0, '0, '0, '0, '0);
        set_req1(1'b0, 7'h0, '0, '0, '0, '0);
        tick();
        #1;
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_count", 32'(conflict_count), 32'd4);

        // req0 only with downstream stalled for 3 cycles.
        out_ready = 1'b0;
        set_req0(1'b1, 7'h33, '0, 20'h12345, 7'd5, 7'd6);
        #1;
        chk("stall_accept_first", 32'(req0_ready), 32'd1);
        tick();
        set_req0(1'b1, 7'h44, '0, 20'h0abcd, 7'd7, 7'd8);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_r0_ready", 32'(req0_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_uopc", 32'(out_uopc), 32'h33);
            chk("stall_out_imm", 32'(out_imm_packed), 32'h12345);
            chk("stall_out_rob", 32'(out_rob_idx), 32'd5);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_r0_ready", 32'(req0_ready), 32'd1);
        tick();
        set_req0(1'b0, 7'h0, '0, '0, '0, '0);
        #1;
        chk("nobubble_valid", 32'(out_valid), 32'd1);
        chk("nobubble_uopc", 32'(out_uopc), 32'h44);
        chk("nobubble_rob", 32'(out_rob_idx), 32'd7);
        tick();

        // Resolve clears the held mask bit; a later mispredict on it is harmless.
        out_ready = 1'b0;
        set_req0(1'b1, 7'h55, 20'h00004, '0, 7'd9, 7'd10);
        tick();
        set_req0(1'b0, 7'h0, '0, '0, '0, '0);
        brupdate_resolve_mask = 20'h00004;
        #1;
        chk("res_before_mask", 32'(out_br_mask), 32'h00004);
        tick();
        brupdate_resolve_mask = '0;
        #1;
        chk("res_after_mask", 32'(out_br_mask), 32'h00000);
        chk("res_after_valid", 32'(out_valid), 32'd1);
        brupdate_mispredict_mask = 20'h00004;
        #1;
        chk("res_mispred_valid", 32'(out_valid), 32'd1);
        tick();
        brupdate_mispredict_mask = '0;
        #1;
        chk("res_still_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();

        // Held uop killed by mispredict; a req1 uop in that cycle is taken.
        out_ready = 1'b0;
        set_req0(1'b1, 7'h66, 20'h00010, '0, 7'd11, 7'd12);
        tick();
        set_req0(1'b0, 7'h0, '0, '0, '0, '0);
        brupdate_mispredict_mask = 20'h00010;
        set_req1(1'b1, 7'h77, '0, 20'h00777, 7'd13, 7'd14);
        #1;
        chk("kill_out_valid", 32'(out_valid), 32'd0);
        chk("kill_r1_ready", 32'(req1_ready), 32'd1);
        tick();
        brupdate_mispredict_mask = '0;
        set_req1(1'b0, 7'h0, '0, '0, '0, '0);
        #1;
        chk("kill_new_valid", 32'(out_valid), 32'd1);
        chk("kill_new_uopc", 32'(out_uopc), 32'h77);
        chk("kill_new_src", 32'(out_src), 32'd1);
        out_ready = 1'b1;
        tick();

        // Incoming req1 killed on arrival: still acked, pointer moves to 0.
        set_req1(1'b1, 7'h78, 20'h80000, '0, 7'd15, 7'd16);
        brupdate_mispredict_mask = 20'h80000;
        #1;
        chk("inkill_r1_ready", 32'(req1_ready), 32'd1);
        tick();
        brupdate_mispredict_mask = '0;
        #1;
        chk("inkill_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        set_req0(1'b1, 7'h11, '0, '0, 7'd17, 7'd18);
        set_req1(1'b1, 7'h22, '0, '0, 7'd19, 7'd20);
        #1;
        chk("inkill_ptr_r0", 32'(req0_ready), 32'd1);
        chk("inkill_ptr_r1", 32'(req1_ready), 32'd0);
        tick();
        #1;
        chk("fl_pre_valid", 32'(out_valid), 32'd1);
        chk("fl_pre_count", 32'(conflict_count), 32'd5);

        // Flush with a held uop and both requesters valid.
        flush = 1'b1;
        #1;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_r0_ready", 32'(req0_ready), 32'd0);
        chk("fl_r1_ready", 32'(req1_ready), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_empty", 32'(out_valid), 32'd0);
        chk("fl_count_hold", 32'(conflict_count), 32'd5);
        chk("fl_ptr_r0", 32'(req0_ready), 32'd0);
        chk("fl_ptr_r1", 32'(req1_ready), 32'd1);
        tick();
        #1;
        chk("fl_after_src", 32'(out_src), 32'd1);
        chk("fl_after_uopc", 32'(out_uopc), 32'h22);
        chk("fl_after_count", 32'(conflict_count), 32'd6);

        // Reset mid-stream clears everything, including the counter and pointer.
        reset_n = 1'b0;
        tick();
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_out_uopc", 32'(out_uopc), 32'd0);
        chk("mrst_out_rob", 32'(out_rob_idx), 32'd0);
        chk("mrst_out_src", 32'(out_src), 32'd0);
        chk("mrst_count", 32'(conflict_count), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("mrst_ptr_r0", 32'(req0_ready), 32'd1);
        chk("mrst_ptr_r1", 32'(req1_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
